// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, ALUOp codes, mux selects,
// state encoding and the control-word layout passed from the output decoder to the top.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_MEMWB  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mcfsm_output_decode.sv
// Combinational state -> control word map; zero latency. Only the memory-handshake strobes
// (IRWrite/PCWrite in FETCH, instr_done in MEMWR) look at mem_ready; everything else is Moore.
module mcfsm_output_decode
    import multicycle_control_fsm_pkg::*;
#(
    parameter int FCW = 4
) (
    input  logic [3:0]        i_state,
    input  logic [FCW-1:0]    i_funct,
    input  logic              i_mem_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [FCW-1:0]    o_func_code
);

    ctrl_t w_c;

    always_comb begin
        w_c         = '0;
        o_func_code = '0;
        case (state_t'(i_state))
            S_FETCH: begin
                w_c.mem_read  = 1'b1;
                w_c.alu_src_b = SRCB_FOUR;
                w_c.alu_op    = ALUOP_ADD;
                w_c.pc_source = PCSRC_ALU;
                w_c.ir_write  = i_mem_ready;
                w_c.pc_write  = i_mem_ready;
            end
            S_DECODE: w_c.alu_src_b = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_c.mem_read = 1'b1;
                w_c.iord     = 1'b1;
            end
            S_MEMWR: begin
                w_c.mem_write  = 1'b1;
                w_c.iord       = 1'b1;
                w_c.instr_done = i_mem_ready;
            end
            S_MEMWB: begin
                w_c.reg_write  = 1'b1;
                w_c.memto_reg  = 1'b1;
                w_c.instr_done = 1'b1;
            end
            S_EXEC: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_B;
                w_c.alu_op    = ALUOP_FUNC;
                o_func_code   = i_funct;
            end
            S_RWB: begin
                w_c.reg_write  = 1'b1;
                w_c.reg_dst    = 1'b1;
                w_c.instr_done = 1'b1;
            end
            // Zero[0] gating of the PC write is done in the datapath
            S_BRANCH: begin
                w_c.alu_src_a     = 1'b1;
                w_c.alu_op        = ALUOP_SUB;
                w_c.pc_write_cond = 1'b1;
                w_c.pc_source     = PCSRC_ALUOUT;
                w_c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_c.pc_write   = 1'b1;
                w_c.pc_source  = PCSRC_JUMP;
                w_c.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                w_c.reg_write  = 1'b1;
                w_c.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_ctrl = w_c;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main control: FETCH/DECODE/EXEC/MEM/WB sequencing; lw 5, sw/R 4, beq/j 3 cycles unstalled.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready. Define MCFSM_ADDI_EN to decode addi (001000).
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FCW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] Opcode,
    input  logic [FCW-1:0] Funct,
    input  logic [1:0]     Zero,
    input  logic           mem_ready,
    output logic [1:0]     ALUOp,
    output logic [FCW-1:0] FuncCode,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegWrite,
    output logic           RegDst,
    output logic [1:0]     PCSource,
    output logic           instr_done,
    output logic           illegal_op
);

    state_t            r_state;
    state_t            w_next;
    logic              r_illegal;
    logic              w_illegal_dec;
    logic [CTRL_W-1:0] w_ctrl_bits;
    ctrl_t             w_ctrl;
    logic [FCW-1:0]    w_func_code;
    logic              w_unused_zero;

    // Zero only qualifies the PC write inside the datapath
    assign w_unused_zero = ^Zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_illegal_dec)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_illegal_dec = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (Opcode == OPW'(OP_LW) || Opcode == OPW'(OP_SW))
                    w_next = S_MEMADR;
                else if (Opcode == OPW'(OP_RTYPE))
                    w_next = S_EXEC;
                else if (Opcode == OPW'(OP_BEQ))
                    w_next = S_BRANCH;
                else if (Opcode == OPW'(OP_J))
                    w_next = S_JUMP;
`ifdef MCFSM_ADDI_EN
                else if (Opcode == OPW'(OP_ADDI))
                    w_next = S_ADDIEX;
`endif
                else begin
                    w_illegal_dec = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_MEMADR: w_next = (Opcode == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_RWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
`ifdef MCFSM_ADDI_EN
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    mcfsm_output_decode #(.FCW(FCW)) u_decode (
        .i_state     (r_state),
        .i_funct     (Funct),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl_bits),
        .o_func_code (w_func_code)
    );

    assign w_ctrl      = ctrl_t'(w_ctrl_bits);
    assign ALUOp       = w_ctrl.alu_op;
    assign FuncCode    = w_func_code;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.memto_reg;
    assign RegWrite    = w_ctrl.reg_write;
    assign RegDst      = w_ctrl.reg_dst;
    assign PCSource    = w_ctrl.pc_source;
    // An undecoded opcode retires in DECODE itself
    assign instr_done  = w_ctrl.instr_done | w_illegal_dec;
    assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed + randomized instruction streams against a per-instruction timeline model.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [1:0] aluop;
        logic [3:0] fc;
        logic       srca;
        logic [1:0] srcb;
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst;
        logic [1:0] pcs;
        logic       done;
        logic       ill;
    } obs_t;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic [3:0] Funct;
    logic [1:0] Zero;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [3:0] FuncCode;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst;
    logic [1:0] PCSource;
    logic       instr_done, illegal_op;

    int   checks = 0;
    int   errors = 0;
    logic m_illegal = 1'b0;
    obs_t w_obs;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPW(6), .FCW(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .ALUOp(ALUOp), .FuncCode(FuncCode), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    assign w_obs = {ALUOp, FuncCode, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, IorD, MemRead,
                    MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, PCSource, instr_done, illegal_op};

    // Expected control word for each cycle role of an instruction
    function automatic obs_t e_base();
        obs_t e = '0;
        e.ill = m_illegal;
        return e;
    endfunction
    function automatic obs_t e_fetch(input logic r);
        obs_t e = e_base();
        e.mrd = 1'b1; e.srcb = 2'b01; e.irw = r; e.pcw = r;
        return e;
    endfunction
    function automatic obs_t e_decode(input logic bad);
        obs_t e = e_base();
        e.srcb = 2'b11; e.done = bad;
        return e;
    endfunction
    function automatic obs_t e_addr();
        obs_t e = e_base();
        e.srca = 1'b1; e.srcb = 2'b10;
        return e;
    endfunction
    function automatic obs_t e_memrd();
        obs_t e = e_base();
        e.mrd = 1'b1; e.iord = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_memwr(input logic r);
        obs_t e = e_base();
        e.mwr = 1'b1; e.iord = 1'b1; e.done = r;
        return e;
    endfunction
    function automatic obs_t e_memwb();
        obs_t e = e_base();
        e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_exec(input logic [3:0] f);
        obs_t e = e_base();
        e.srca = 1'b1; e.aluop = 2'b10; e.fc = f;
        return e;
    endfunction
    function automatic obs_t e_rwb();
        obs_t e = e_base();
        e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_branch();
        obs_t e = e_base();
        e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_jump();
        obs_t e = e_base();
        e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_addiwb();
        obs_t e = e_base();
        e.rw = 1'b1; e.done = 1'b1;
        return e;
    endfunction

    function automatic bit is_illegal(input logic [5:0] op);
        bit ok = (op == RT) || (op == LW) || (op == SW) || (op == BEQ) || (op == J);
`ifdef MCFSM_ADDI_EN
        ok = ok || (op == ADDI);
`endif
        return !ok;
    endfunction

    function automatic int lat(input logic [5:0] op);
        if (is_illegal(op)) return 2;
        case (op)
            LW:      return 5;
            SW:      return 4;
            RT:      return 4;
            BEQ:     return 3;
            J:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check_now(input obs_t e, input string tag);
        checks++;
        assert (w_obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, e);
        end
    endtask

    task automatic step(input obs_t e, input string tag);
        @(negedge clk);
        check_now(e, tag);
        @(posedge clk);
        #1;
    endtask

    // Fields that must not influence the current state
    task automatic junk();
        Opcode    = 6'($urandom);
        Funct     = 4'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [3:0] f, input int fst,
                             input int mst, input string tag);
        int   n = 0;
        logic bad;
        bad = is_illegal(op);
        for (int i = 0; i < fst; i++) begin
            junk(); mem_ready = 1'b0;
            step(e_fetch(1'b0), {tag, ":fetch_stall"}); n++;
        end
        junk(); mem_ready = 1'b1;
        step(e_fetch(1'b1), {tag, ":fetch"}); n++;
        junk(); Opcode = op;
        step(e_decode(bad), {tag, ":decode"}); n++;
        if (bad) begin
            m_illegal = 1'b1;
        end else begin
            case (op)
                RT: begin
                    junk(); Funct = f;
                    step(e_exec(f), {tag, ":exec"}); n++;
                    junk();
                    step(e_rwb(), {tag, ":rwb"}); n++;
                end
                LW, SW: begin
                    mem_ready = 1'($urandom); Funct = 4'($urandom);
                    step(e_addr(), {tag, ":memadr"}); n++;
                    for (int i = 0; i < mst; i++) begin
                        junk(); mem_ready = 1'b0;
                        if (op == LW) step(e_memrd(), {tag, ":memrd_stall"});
                        else          step(e_memwr(1'b0), {tag, ":memwr_stall"});
                        n++;
                    end
                    junk(); mem_ready = 1'b1;
                    if (op == LW) begin
                        step(e_memrd(), {tag, ":memrd"}); n++;
                        junk();
                        step(e_memwb(), {tag, ":memwb"}); n++;
                    end else begin
                        step(e_memwr(1'b1), {tag, ":memwr"}); n++;
                    end
                end
                BEQ: begin
                    junk();
                    step(e_branch(), {tag, ":branch"}); n++;
                end
                J: begin
                    junk();
                    step(e_jump(), {tag, ":jump"}); n++;
                end
                default: begin
                    junk();
                    step(e_addr(), {tag, ":addiex"}); n++;
                    junk();
                    step(e_addiwb(), {tag, ":addiwb"}); n++;
                end
            endcase
        end
        if (fst == 0 && mst == 0) begin
            checks++;
            assert (n === lat(op)) else begin
                errors++;
                $error("FAIL %s:latency observed=%0d expected=%0d", tag, n, lat(op));
            end
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = RT; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = J; ops[5] = ADDI;

        rst = 1'b1; Opcode = '0; Funct = '0; Zero = 2'b01; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(e_base(), "in_reset");
        rst = 1'b0;
        step(e_base(), "idle");

        run_instr(RT, 4'b0010, 0, 0, "rtype");
        run_instr(LW, 4'h0, 0, 3, "lw_stall3");
        run_instr(LW, 4'h0, 0, 0, "lw");
        run_instr(SW, 4'h0, 0, 0, "sw");
        Zero = 2'b01;
        run_instr(BEQ, 4'h0, 0, 0, "beq");
        run_instr(J, 4'h0, 2, 0, "fetch_stall2");
        run_instr(ADDI, 4'h0, 0, 0, "addi");
        run_instr(6'b111111, 4'h0, 0, 0, "illegal");
        run_instr(J, 4'h0, 0, 0, "after_illegal");

        // Abort a store while MemWrite is held waiting for memory
        mem_ready = 1'b1;
        step(e_fetch(1'b1), "abort:fetch");
        Opcode = SW;
        step(e_decode(1'b0), "abort:decode");
        step(e_addr(), "abort:memadr");
        mem_ready = 1'b0;
        step(e_memwr(1'b0), "abort:memwr");
        check_now(e_memwr(1'b0), "abort:memwr_hold");
        rst = 1'b1;
        m_illegal = 1'b0;
        #1;
        check_now(e_base(), "abort:reset_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(e_base(), "abort:idle");

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            Zero = 2'($urandom);
            run_instr(op, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
